// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and line levels for the UART frame controller.
// Build option: UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_tx_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_t;
`endif

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// parity_calc: combinational parity bit for the frame currently on the line.
// Only built with UART_TX_PARITY_EN; the default build has no parity logic at all.
// Even parity is the XOR-reduce of the data, odd parity its inverse.
`ifdef UART_TX_PARITY_EN
module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  input  logic                  i_par_en,
  output logic                  o_par_bit
);

  assign o_par_bit = i_par_en & ((^i_data) ^ i_par_typ);

endmodule
`endif

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller. Accepts bytes over valid/ready into a
// one-entry hold register and sequences the external serializer through
// start / data / [parity] / stop, one bit per CLK cycle, back-to-back when possible.
// Build option: UART_TX_PARITY_EN adds PAR_EN/PAR_TYP ports and the PARITY state.
//
// state  | meaning
// IDLE   | line high, waiting for a held byte
// START  | start bit on the line, serializer loads the frame register
// DATA   | serializer shifts, line follows ser_data (LSB first)
// PARITY | parity bit of the frame register (parity build only)
// STOP   | stop bit; chains straight into START if a byte is held
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  ser_load,
  output logic [DATA_WIDTH-1:0] ser_pdata,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_t             r_state;
  tx_state_t             w_next_state;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_ser_pdata;
  logic                  w_push;
  logic                  w_pop;

  assign DATA_READY = ~r_hold_full;
  assign w_push     = DATA_VALID & ~r_hold_full;
  // The hold register is popped on every edge that enters START.
  assign w_pop      = r_hold_full & ((r_state == IDLE) | (r_state == STOP));
  assign ser_pdata  = r_ser_pdata;

  // Hold register push/pop and frame register load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ser_pdata <= '0;
    end else begin
      if (w_pop) begin
        r_ser_pdata <= r_hold;
      end
      if (w_push) begin
        r_hold      <= P_DATA;
        r_hold_full <= 1'b1;
      end else if (w_pop) begin
        r_hold_full <= 1'b0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic r_hold_par_en;
  logic r_hold_par_typ;
  logic r_par_en;
  logic r_par_typ;
  logic w_par_bit;

  // Parity settings travel with their byte: captured at push, promoted at pop, so a
  // byte queued behind an in-flight frame cannot change that frame's parity.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_par_en  <= 1'b0;
      r_hold_par_typ <= 1'b0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
    end else begin
      if (w_push) begin
        r_hold_par_en  <= PAR_EN;
        r_hold_par_typ <= PAR_TYP;
      end
      if (w_pop) begin
        r_par_en  <= r_hold_par_en;
        r_par_typ <= r_hold_par_typ;
      end
    end
  end

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (r_ser_pdata),
    .i_par_typ(r_par_typ),
    .i_par_en (r_par_en),
    .o_par_bit(w_par_bit)
  );
`endif

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and line/serializer controls; outputs depend on state only.
  always_comb begin
    w_next_state = r_state;
    ser_en       = 1'b0;
    ser_load     = 1'b0;
    TX_OUT       = TX_IDLE_LEVEL;
    Busy         = 1'b1;
    case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (r_hold_full) begin
          w_next_state = START;
        end
      end
      START: begin
        TX_OUT       = START_BIT;
        ser_load     = 1'b1;
        w_next_state = DATA;
      end
      DATA: begin
        ser_en = 1'b1;
        TX_OUT = ser_data;
        if (ser_done) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = r_par_en ? PARITY : STOP;
`else
          w_next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        TX_OUT       = w_par_bit;
        w_next_state = STOP;
      end
`endif
      STOP: begin
        TX_OUT       = STOP_BIT;
        w_next_state = r_hold_full ? START : IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with a behavioural serializer,
// a line receiver and a scoreboard of expected frames.
// Build option: UART_TX_PARITY_EN enables the parity frames.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    bit            par_en;
    bit            par_odd;
    bit            b2b;
  } exp_t;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          DATA_READY;
  logic          par_en;
  logic          par_typ;
  logic          ser_done;
  logic          ser_data;
  logic          ser_en;
  logic          ser_load;
  logic [DW-1:0] ser_pdata;
  logic          TX_OUT;
  logic          Busy;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];
  int   frames_done   = 0;
  int   cyc           = 0;
  int   last_stop_cyc = -10;
  int   rx_state      = 0;
  int   rx_cnt        = 0;
  logic [DW-1:0] rx_data;
  exp_t cur;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY),
`ifdef UART_TX_PARITY_EN
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
`endif
    .ser_done  (ser_done),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .ser_load  (ser_load),
    .ser_pdata (ser_pdata),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural serializer: loads on ser_load, shifts LSB first on ser_en,
  // ser_done while the last data bit is presented.
  logic [DW-1:0] m_shift;
  logic [3:0]    m_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_shift <= '0;
      m_cnt   <= '0;
    end else if (ser_load) begin
      m_shift <= ser_pdata;
      m_cnt   <= '0;
    end else if (ser_en) begin
      m_shift <= m_shift >> 1;
      m_cnt   <= m_cnt + 4'd1;
    end
  end
  assign ser_data = m_shift[0];
  assign ser_done = ser_en && (m_cnt == 4'(DW - 1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line receiver: rebuilds each frame from TX_OUT and checks it against the scoreboard.
  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      rx_state = 0;
      rx_cnt   = 0;
    end else begin
      chk("load_en_exclusive", {31'd0, ser_en & ser_load}, 32'd0);
      case (rx_state)
        0: begin
          if (TX_OUT === 1'b0) begin
            chk("frame_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) cur = sb.pop_front();
            else begin
              cur.data = 'x; cur.par_en = 0; cur.par_odd = 0; cur.b2b = 0;
            end
            if (cur.b2b) chk("b2b_gap", cyc - last_stop_cyc, 32'd1);
            chk("busy_start", {31'd0, Busy}, 32'd1);
            rx_cnt   = 0;
            rx_state = 1;
          end
        end
        1: begin
          rx_data[rx_cnt] = TX_OUT;
          chk("busy_data", {31'd0, Busy}, 32'd1);
          rx_cnt++;
          if (rx_cnt == DW) rx_state = cur.par_en ? 2 : 3;
        end
        2: begin
          chk("parity_bit", {31'd0, TX_OUT},
              {31'd0, cur.par_odd ? ~(^cur.data) : (^cur.data)});
          chk("busy_parity", {31'd0, Busy}, 32'd1);
          rx_state = 3;
        end
        default: begin
          chk("stop_bit", {31'd0, TX_OUT}, 32'd1);
          chk("busy_stop", {31'd0, Busy}, 32'd1);
          chk("frame_data", {24'd0, rx_data}, {24'd0, cur.data});
          last_stop_cyc = cyc;
          frames_done++;
          rx_state = 0;
        end
      endcase
    end
  end

  // One-cycle valid pulse; the byte is expected to go out only if accepted.
  task automatic send(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                      input bit accept, input bit b2b);
    exp_t e;
    @(negedge CLK);
    chk("ready_at_push", {31'd0, DATA_READY}, {31'd0, accept});
    P_DATA     = d;
    par_en     = pen;
    par_typ    = ptyp;
    DATA_VALID = 1'b1;
    if (accept) begin
      e.data = d; e.par_en = pen; e.par_odd = ptyp; e.b2b = b2b;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1 DATA_VALID = 1'b0;
  endtask

  // Valid held until accepted; reports how many cycles it waited.
  task automatic hold_send(input logic [DW-1:0] d, input bit b2b, output int waited);
    exp_t e;
    bit   rdy;
    bit   accepted;
    e.data = d; e.par_en = 0; e.par_odd = 0; e.b2b = b2b;
    sb.push_back(e);
    accepted = 0;
    waited   = 0;
    @(negedge CLK);
    P_DATA     = d;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    DATA_VALID = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rdy = DATA_READY;
      @(posedge CLK);
      if (rdy) begin
        accepted = 1;
        break;
      end
      waited++;
      @(negedge CLK);
    end
    #1 DATA_VALID = 1'b0;
    chk("hold_send_accepted", {31'd0, accepted}, 32'd1);
  endtask

  task automatic wait_frames(input int n);
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      #1;
      if (frames_done >= n) break;
    end
    chk("frame_timeout", {31'd0, frames_done >= n}, 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge CLK);
    chk(tag, {29'd0, Busy, TX_OUT, DATA_READY}, 32'b011);
  endtask

  int waited;

  initial begin
    RST        = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #1;
    chk("rst_tx_out",     {31'd0, TX_OUT},     32'd1);
    chk("rst_busy",       {31'd0, Busy},       32'd0);
    chk("rst_ready",      {31'd0, DATA_READY}, 32'd1);
    chk("rst_ser_en",     {31'd0, ser_en},     32'd0);
    chk("rst_ser_load",   {31'd0, ser_load},   32'd0);
    chk("rst_ser_pdata",  {24'd0, ser_pdata},  32'd0);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;

    // 0xA5, parity off: cycle-accurate start of frame, then full frame via receiver.
    send(8'hA5, 0, 0, 1, 0);
    @(negedge CLK);
    chk("a5_c1_busy",  {31'd0, Busy},       32'd0);
    chk("a5_c1_ready", {31'd0, DATA_READY}, 32'd0);
    chk("a5_c1_tx",    {31'd0, TX_OUT},     32'd1);
    @(negedge CLK);
    chk("a5_c2_tx",     {31'd0, TX_OUT},     32'd0);
    chk("a5_c2_busy",   {31'd0, Busy},       32'd1);
    chk("a5_c2_load",   {31'd0, ser_load},   32'd1);
    chk("a5_c2_ready",  {31'd0, DATA_READY}, 32'd1);
    chk("a5_c2_pdata",  {24'd0, ser_pdata},  32'hA5);
    wait_frames(1);
    expect_idle("a5_idle_after");

`ifdef UART_TX_PARITY_EN
    // 0x07 with even then odd parity: 11-bit frames.
    send(8'h07, 1, 0, 1, 0);
    wait_frames(frames_done + 1);
    expect_idle("par_even_idle_after");
    send(8'h07, 1, 1, 1, 0);
    wait_frames(frames_done + 1);
    expect_idle("par_odd_idle_after");
`endif

    // 0x11, 0x22 while busy, 0x33 dropped, 0x44 offered on the pop edge.
    begin
      int base;
      base = frames_done;
      send(8'h11, 0, 0, 1, 0);
      @(negedge CLK);
      send(8'h22, 0, 0, 1, 1);
      send(8'h33, 0, 0, 0, 0);
      repeat (7) @(negedge CLK);
      hold_send(8'h44, 1, waited);
      chk("pop_edge_accept_delay", waited, 32'd1);
      wait_frames(base + 3);
      expect_idle("b2b_idle_after");
    end

    // Reset during data bit 4 with a byte also held: both are discarded.
    send(8'h3C, 0, 0, 1, 0);
    @(negedge CLK);
    send(8'h99, 0, 0, 1, 0);
    repeat (4) @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_tx_out",  {31'd0, TX_OUT},     32'd1);
    chk("midrst_busy",    {31'd0, Busy},       32'd0);
    chk("midrst_ready",   {31'd0, DATA_READY}, 32'd1);
    chk("midrst_ser_en",  {31'd0, ser_en},     32'd0);
    sb.delete();
    @(negedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("midrst_hold_dropped", {30'd0, Busy, TX_OUT}, 32'b01);
    send(8'h5A, 0, 0, 1, 0);
    wait_frames(frames_done + 1);
    expect_idle("5a_idle_after");

    // 0xFF without parity: 10-bit frame.
    send(8'hFF, 0, 0, 1, 0);
    wait_frames(frames_done + 1);
    expect_idle("ff_idle_after");

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
